// File: rtl/pixel_combinator.sv
// Raster-order consumer of the per-engine result queues: broadcasts the next coordinate,
// captures the matching queue's colour and streams pixels out. Optional STALL_TIMEOUT_EN adds a stall watchdog.
module pixel_combinator #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned RBG_SIZE       = 24,
    parameter int unsigned NUM_ENGINES    = 4,
    parameter int unsigned IMG_WIDTH      = 640,
    parameter int unsigned IMG_HEIGHT     = 480,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              start,
    input  logic [NUM_ENGINES-1:0]            q_en,
    input  logic [NUM_ENGINES*DATA_WIDTH-1:0] q_xfront,
    input  logic [NUM_ENGINES*DATA_WIDTH-1:0] q_yfront,
    input  logic [NUM_ENGINES*RBG_SIZE-1:0]   q_colour,
    output logic [DATA_WIDTH-1:0]             xpixel_check,
    output logic [DATA_WIDTH-1:0]             ypixel_check,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [RBG_SIZE-1:0]               out_colour,
    output logic                              out_sof,
    output logic                              out_eol,
    output logic                              frame_done,
    output logic                              busy,
    output logic                              dup_err
`ifdef STALL_TIMEOUT_EN
    ,
    output logic                              stall_err
`endif
);

    localparam int unsigned SEL_W = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;
    localparam logic [DATA_WIDTH-1:0] X_LAST = DATA_WIDTH'(IMG_WIDTH - 1);
    localparam logic [DATA_WIDTH-1:0] Y_LAST = DATA_WIDTH'(IMG_HEIGHT - 1);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   cur_x_q, cur_x_d;
    logic [DATA_WIDTH-1:0]   cur_y_q, cur_y_d;
    logic                    pending_q, pending_d;
    logic [SEL_W-1:0]        sel_q, sel_d;
    logic                    pend_sof_q, pend_sof_d;
    logic                    pend_eol_q, pend_eol_d;
    logic                    pend_zero_q, pend_zero_d;
    logic                    scan_done_q, scan_done_d;
    logic                    out_valid_q, out_valid_d;
    logic [RBG_SIZE-1:0]     out_colour_q, out_colour_d;
    logic                    out_sof_q, out_sof_d;
    logic                    out_eol_q, out_eol_d;
    logic                    frame_done_q, frame_done_d;
    logic                    busy_q, busy_d;
    logic                    dup_err_q, dup_err_d;

    logic                    check_en;
    logic [NUM_ENGINES-1:0]  hit;
    logic                    any_hit;
    logic                    multi_hit;
    logic [SEL_W-1:0]        hit_sel;
    logic [RBG_SIZE-1:0]     sel_colour;
    logic                    tmo_fire;
    logic                    advance;

    // Only broadcast when a pop can be captured without overwriting an unaccepted pixel
    assign check_en = (state_q == SCAN) && !pending_q && !scan_done_q
                      && (!out_valid_q || out_ready);

    assign xpixel_check = check_en ? cur_x_q : '1;
    assign ypixel_check = check_en ? cur_y_q : '1;

    always_comb begin
        hit     = '0;
        hit_sel = '0;
        for (int i = 0; i < NUM_ENGINES; i++) begin
            hit[i] = check_en && q_en[i]
                     && (q_xfront[i*DATA_WIDTH +: DATA_WIDTH] == cur_x_q)
                     && (q_yfront[i*DATA_WIDTH +: DATA_WIDTH] == cur_y_q);
        end
        for (int i = int'(NUM_ENGINES) - 1; i >= 0; i--) begin
            if (hit[i]) begin
                hit_sel = SEL_W'(i);
            end
        end
        any_hit   = |hit;
        multi_hit = ($countones(hit) > 1);
    end

    always_comb begin
        sel_colour = '0;
        for (int i = 0; i < NUM_ENGINES; i++) begin
            if (sel_q == SEL_W'(i)) begin
                sel_colour = q_colour[i*RBG_SIZE +: RBG_SIZE];
            end
        end
    end

`ifdef STALL_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic            stall_err_q, stall_err_d;

    assign tmo_fire = check_en && !any_hit && (tmo_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        tmo_cnt_d   = tmo_cnt_q;
        stall_err_d = stall_err_q;
        if (state_q == IDLE) begin
            tmo_cnt_d = '0;
        end else if (any_hit || tmo_fire) begin
            tmo_cnt_d = '0;
        end else if (check_en) begin
            tmo_cnt_d = tmo_cnt_q + TO_W'(1);
        end
        if (tmo_fire) begin
            stall_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmo_cnt_q   <= '0;
            stall_err_q <= 1'b0;
        end else begin
            tmo_cnt_q   <= tmo_cnt_d;
            stall_err_q <= stall_err_d;
        end
    end

    assign stall_err = stall_err_q;
`else
    assign tmo_fire = 1'b0;
`endif

    assign advance = any_hit || tmo_fire;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SCAN;
            SCAN:    if (scan_done_q && !pending_q && out_valid_q && out_ready) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and output next values
    always_comb begin
        cur_x_d      = cur_x_q;
        cur_y_d      = cur_y_q;
        pending_d    = pending_q;
        sel_d        = sel_q;
        pend_sof_d   = pend_sof_q;
        pend_eol_d   = pend_eol_q;
        pend_zero_d  = pend_zero_q;
        scan_done_d  = scan_done_q;
        out_valid_d  = out_valid_q;
        out_colour_d = out_colour_q;
        out_sof_d    = out_sof_q;
        out_eol_d    = out_eol_q;
        dup_err_d    = dup_err_q;
        frame_done_d = (state_d == DONE);
        busy_d       = (state_d != IDLE);

        if (state_q == IDLE && start) begin
            cur_x_d     = '0;
            cur_y_d     = '0;
            scan_done_d = 1'b0;
        end

        if (advance) begin
            pending_d   = 1'b1;
            sel_d       = hit_sel;
            pend_sof_d  = (cur_x_q == '0) && (cur_y_q == '0);
            pend_eol_d  = (cur_x_q == X_LAST);
            pend_zero_d = !any_hit;
            if (cur_x_q == X_LAST) begin
                cur_x_d = '0;
                cur_y_d = cur_y_q + DATA_WIDTH'(1);
                if (cur_y_q == Y_LAST) begin
                    scan_done_d = 1'b1;
                end
            end else begin
                cur_x_d = cur_x_q + DATA_WIDTH'(1);
            end
            if (multi_hit) begin
                dup_err_d = 1'b1;
            end
        end

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        // Queue colour is registered, so capture lands one cycle after the hit
        if (pending_q) begin
            pending_d    = 1'b0;
            out_valid_d  = 1'b1;
            out_colour_d = pend_zero_q ? '0 : sel_colour;
            out_sof_d    = pend_sof_q;
            out_eol_d    = pend_eol_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur_x_q      <= '0;
            cur_y_q      <= '0;
            pending_q    <= 1'b0;
            sel_q        <= '0;
            pend_sof_q   <= 1'b0;
            pend_eol_q   <= 1'b0;
            pend_zero_q  <= 1'b0;
            scan_done_q  <= 1'b0;
            out_valid_q  <= 1'b0;
            out_colour_q <= '0;
            out_sof_q    <= 1'b0;
            out_eol_q    <= 1'b0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
            dup_err_q    <= 1'b0;
        end else begin
            cur_x_q      <= cur_x_d;
            cur_y_q      <= cur_y_d;
            pending_q    <= pending_d;
            sel_q        <= sel_d;
            pend_sof_q   <= pend_sof_d;
            pend_eol_q   <= pend_eol_d;
            pend_zero_q  <= pend_zero_d;
            scan_done_q  <= scan_done_d;
            out_valid_q  <= out_valid_d;
            out_colour_q <= out_colour_d;
            out_sof_q    <= out_sof_d;
            out_eol_q    <= out_eol_d;
            frame_done_q <= frame_done_d;
            busy_q       <= busy_d;
            dup_err_q    <= dup_err_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_colour = out_colour_q;
    assign out_sof    = out_sof_q;
    assign out_eol    = out_eol_q;
    assign frame_done = frame_done_q;
    assign busy       = busy_q;
    assign dup_err    = dup_err_q;

endmodule
